// File: rtl/digit_recognizer_pkg.sv
// digit_recognizer_pkg: fetch FSM states and weight-memory layout constants
package digit_recognizer_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, PRESENT, DONE} fetch_state_t;
  localparam int N_HIDDEN = 8;
  localparam int HID_WORDS = 36;
  localparam int N_OUT = 10;
  localparam int OUT_WORDS = 2;
  localparam int HID_BASE = 0;
  localparam int OUT_BASE = HID_BASE + N_HIDDEN * (HID_WORDS + 1);
  localparam int LAST_ADDR = OUT_BASE + N_OUT * (OUT_WORDS + 1) - 1;
endpackage

// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: neuron/word counters driving flash address and word-type flags
module fetch_addr_gen #(
  parameter int N_HIDDEN = digit_recognizer_pkg::N_HIDDEN,
  parameter int HID_WORDS = digit_recognizer_pkg::HID_WORDS,
  parameter int N_OUT = digit_recognizer_pkg::N_OUT,
  parameter int OUT_WORDS = digit_recognizer_pkg::OUT_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  output logic [15:0] address,
  output logic        is_bias,
  output logic        is_output,
  output logic [3:0]  neuron,
  output logic        last_word,
  output logic        final_word
);
  localparam int CW = $clog2(HID_WORDS + 1);
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] word_max;
  logic layer_end;
  always_comb begin
    word_max = is_output ? CW'(OUT_WORDS) : CW'(HID_WORDS);
    last_word = word_cnt == word_max;
    is_bias = word_cnt == '0;
    layer_end = neuron == (is_output ? 4'(N_OUT - 1) : 4'(N_HIDDEN - 1));
    final_word = last_word && layer_end && is_output;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      address <= '0;
      word_cnt <= '0;
      neuron <= '0;
      is_output <= 1'b0;
    end else if (adv) begin
      address <= address + 16'd1;
      word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      neuron <= !last_word ? neuron : layer_end ? 4'd0 : neuron + 4'd1;
      is_output <= is_output || (last_word && layer_end);
    end
  end
endmodule

// File: rtl/flash_fetch_ctrl.sv
// flash_fetch_ctrl: sequences network weights out of parallel flash with valid/ready handoff
module flash_fetch_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int N_HIDDEN = digit_recognizer_pkg::N_HIDDEN,
  parameter int HID_WORDS = digit_recognizer_pkg::HID_WORDS,
  parameter int N_OUT = digit_recognizer_pkg::N_OUT,
  parameter int OUT_WORDS = digit_recognizer_pkg::OUT_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] address,
  input  logic [15:0] data,
  output logic        ce,
  output logic        oe,
  output logic        we,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        is_bias,
  output logic        is_output,
  output logic [3:0]  neuron,
  output logic        last_word,
  output logic        busy,
  output logic        done
);
  import digit_recognizer_pkg::*;
  localparam int WW = $clog2(WAIT_CYCLES + 2);
  fetch_state_t state, state_next;
  logic [WW-1:0] wait_cnt;
  logic wait_done, adv, clr, gen_bias, gen_output, gen_last, final_word;
  logic [3:0] gen_neuron;
  fetch_addr_gen #(
    .N_HIDDEN(N_HIDDEN),
    .HID_WORDS(HID_WORDS),
    .N_OUT(N_OUT),
    .OUT_WORDS(OUT_WORDS)
  ) u_gen (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .adv(adv),
    .address(address),
    .is_bias(gen_bias),
    .is_output(gen_output),
    .neuron(gen_neuron),
    .last_word(gen_last),
    .final_word(final_word)
  );
  always_comb begin
    wait_done = wait_cnt == WW'(WAIT_CYCLES);
    state_next = state;
    case (state)
      IDLE:    state_next = start ? ADDR : IDLE;
      ADDR:    state_next = wait_done ? PRESENT : ADDR;
      PRESENT: state_next = !word_ready ? PRESENT : final_word ? DONE : ADDR;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
    adv = state == PRESENT && word_ready && !abort && !final_word;
    clr = state_next == IDLE;
    busy = state != IDLE;
    word_valid = state == PRESENT;
    done = state == DONE;
    ce = state == ADDR;
    oe = state == ADDR;
    we = 1'b0;
    is_bias = busy && gen_bias;
    is_output = busy && gen_output;
    last_word = busy && gen_last;
    neuron = busy ? gen_neuron : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      word <= '0;
    end else begin
      state <= state_next;
      wait_cnt <= (state == ADDR && !wait_done) ? wait_cnt + 1'b1 : '0;
      if (state == ADDR && wait_done && !abort) word <= data;
    end
  end
endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// tb_flash_fetch_ctrl: random-backpressure sweeps against a layout-arithmetic reference model
module tb_flash_fetch_ctrl;
  localparam int NH = 8, HW = 36, NO = 10, OW = 2, W = 2;
  localparam int OB = NH * (HW + 1);
  localparam int LAST = OB + NO * (OW + 1) - 1;
  logic clk = 0, rst = 1, start = 0, abort = 0, word_ready = 1;
  logic [15:0] data, address, word;
  logic ce, oe, we, word_valid, is_bias, is_output, last_word, busy, done;
  logic [3:0] neuron;
  logic z_rst = 1, z_start = 0, z_abort = 0, z_ready = 1;
  logic [15:0] z_data, z_address, z_word;
  logic z_ce, z_oe, z_we, z_valid, z_bias, z_output, z_last, z_busy, z_done;
  logic [3:0] z_neuron;
  logic [15:0] mem [0:LAST];
  int tests = 0, fails = 0;
  int sc = 0, exp_addr = 0, ndone = 0, cyc = 0, last_rise = -1;
  int z_exp = 0, z_rise = -1;
  logic [15:0] sc_addr = 0;
  bit exp_done = 0, prev_valid = 0, per_en = 0, rnd = 0, z_prev = 0;
  always #5 clk = ~clk;
  // flash returns garbage until the address has been stable for W access cycles
  assign data = (sc >= W) ? mem[address] : ~mem[address];
  assign z_data = mem[z_address];
  flash_fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .address(address), .data(data),
    .ce(ce), .oe(oe), .we(we), .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .is_bias(is_bias), .is_output(is_output), .neuron(neuron), .last_word(last_word),
    .busy(busy), .done(done)
  );
  flash_fetch_ctrl #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(z_rst), .start(z_start), .abort(z_abort), .address(z_address), .data(z_data),
    .ce(z_ce), .oe(z_oe), .we(z_we), .word(z_word), .word_valid(z_valid), .word_ready(z_ready),
    .is_bias(z_bias), .is_output(z_output), .neuron(z_neuron), .last_word(z_last),
    .busy(z_busy), .done(z_done)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] flags(int a);
    int n, w;
    logic o, l;
    if (a < OB) begin
      n = a / (HW + 1); w = a % (HW + 1); o = 0; l = (w == HW);
    end else begin
      n = (a - OB) / (OW + 1); w = (a - OB) % (OW + 1); o = 1; l = (w == OW);
    end
    return {w == 0, o, 4'(n), l};
  endfunction
  function automatic logic [41:0] all_outs();
    return {address, word, word_valid, is_bias, is_output, neuron, last_word, busy, done, ce, oe, we};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) word_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic wait_valid(int a);
    for (int i = 0; i < 5000; i++) begin
      if (word_valid && address == 16'(a)) return;
      step();
    end
    check("wait_valid_timeout", 0, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 5000; i++) begin
      if (done) return;
      step();
    end
    check("wait_done_timeout", 0, 1);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (sc_addr == address) sc++;
    else begin
      sc = 0;
      sc_addr = address;
    end
    if (rst) begin
      exp_addr = 0;
      exp_done = 0;
    end else begin
      if (done || exp_done) check("done", done, exp_done);
      if (done) ndone++;
      exp_done = 0;
      check("ce_oe_we", {ce, oe, we}, (busy && !word_valid && !done) ? 3'b110 : 3'b000);
      if (word_valid) begin
        check("addr", address, exp_addr);
        check("flags", {is_bias, is_output, neuron, last_word}, flags(exp_addr));
        check("word", word, mem[exp_addr]);
        if (!prev_valid && per_en && last_rise >= 0) check("period", cyc - last_rise, W + 2);
        if (!prev_valid) last_rise = cyc;
        if (word_ready && !abort) begin
          if (exp_addr == LAST) exp_done = 1;
          else exp_addr++;
        end
      end
      if (start && !busy && !abort) begin
        exp_addr = 0;
        last_rise = -1;
      end
    end
    prev_valid = word_valid;
  end
  always @(negedge clk) begin
    if (z_valid) begin
      check("w0_addr", z_address, z_exp);
      check("w0_word", z_word, mem[z_exp]);
      if (!z_prev && z_rise >= 0) check("w0_period", cyc - z_rise, 2);
      if (!z_prev) z_rise = cyc;
      z_exp++;
    end
    z_prev = z_valid;
  end
  initial begin
    logic [41:0] snap;
    int lat;
    foreach (mem[i]) mem[i] = 16'($urandom);
    step();
    step();
    check("reset_outs", all_outs(), 0);
    rst = 0;
    z_rst = 0;
    step();
    check("idle_outs", all_outs(), 0);
    per_en = 1;
    start = 1;
    step();
    start = 0;
    lat = 1;
    while (!word_valid && lat < 50) begin
      step();
      lat++;
    end
    check("latency", lat, W + 2);
    wait_valid(100);
    start = 1;
    step();
    start = 0;
    wait_done();
    step();
    step();
    check("done_cnt_sweep1", ndone, 1);
    check("busy_after_done", busy, 0);
    per_en = 0;
    rnd = 1;
    start = 1;
    step();
    start = 0;
    wait_valid(40);
    rnd = 0;
    word_ready = 0;
    snap = all_outs();
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", all_outs(), snap);
    end
    word_ready = 1;
    step();
    check("bp_release_addr_moved", address, 41);
    rnd = 1;
    wait_valid(200);
    rnd = 0;
    word_ready = 1;
    abort = 1;
    step();
    abort = 0;
    check("abort_outs", {word_valid, ce, oe, busy, done}, 0);
    for (int i = 0; i < 5; i++) step();
    check("abort_no_done", ndone, 1);
    rnd = 1;
    start = 1;
    step();
    start = 0;
    wait_valid(150);
    rst = 1;
    step();
    check("rst_mid_outs", all_outs(), 0);
    rst = 0;
    step();
    start = 1;
    step();
    start = 0;
    wait_done();
    step();
    check("done_cnt_final", ndone, 2);
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    check("start_abort_idle", busy, 0);
    step();
    check("start_abort_idle2", {busy, ce}, 0);
    rnd = 0;
    z_start = 1;
    step();
    z_start = 0;
    for (int i = 0; i < 2000 && !z_done; i++) step();
    check("w0_done", z_done, 1);
    check("w0_words", z_exp, LAST + 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/flash_fetch_ctrl.md
FLASH_FETCH_CTRL -- requirements
Module: flash_fetch_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra flash access cycles after an address change, before data is sampled.
REQ-002 Parameter N_HIDDEN, default 8: hidden neurons.
REQ-003 Parameter HID_WORDS, default 36: weight words per hidden neuron.
REQ-004 Parameter N_OUT, default 10: output neurons.
REQ-005 Parameter OUT_WORDS, default 2: weight words per output neuron.
REQ-006 Port clk, input, 1: the single clock for all logic.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: single-cycle request to begin a full network fetch.
REQ-009 Port abort, input, 1: terminates the fetch in progress.
REQ-010 Port address, output, 16: flash word address.
REQ-011 Port data, input, 16: flash read data.
REQ-012 Port ce, output, 1: flash chip enable, active-high.
REQ-013 Port oe, output, 1: flash output enable, active-high.
REQ-014 Port we, output, 1: flash write enable, held 0.
REQ-015 Port word, output, 16: captured flash word.
REQ-016 Port word_valid, output, 1: word is valid.
REQ-017 Port word_ready, input, 1: consumer accepts the word.
REQ-018 Port is_bias, output, 1: word is a neuron bias.
REQ-019 Port is_output, output, 1: word belongs to the output layer.
REQ-020 Port neuron, output, 4: neuron index within the current layer.
REQ-021 Port last_word, output, 1: final word of the current neuron.
REQ-022 Port busy, output, 1: a fetch is in progress.
REQ-023 Port done, output, 1: one-cycle pulse when the fetch completes.

Function
REQ-024 Memory layout: hidden neuron n occupies base n*(HID_WORDS+1), bias first, then HID_WORDS weight words; output neuron o occupies base N_HIDDEN*(HID_WORDS+1) + o*(OUT_WORDS+1), same order. The total with defaults is 326 words, addresses 0..325.
REQ-025 States: IDLE, ADDR, PRESENT, DONE.
REQ-026 IDLE: when start=1, go to ADDR with address=0, and busy=1 from the next cycle.
REQ-027 ADDR: lasts exactly WAIT_CYCLES+1 cycles, with ce=oe=1 and address stable; in the last cycle, data is registered into word, and the state moves to PRESENT.
REQ-028 PRESENT: word_valid=1; word, is_bias, is_output, neuron, last_word and address are held stable until word_valid&&word_ready.
REQ-029 Acceptance of the word at the final address (325 by default) goes to DONE; any other acceptance increments address and returns to ADDR.
REQ-030 DONE: done=1 for one cycle, then the state returns to IDLE with busy=0.
REQ-031 Latency: first word_valid occurs WAIT_CYCLES+2 cycles after the start-sample cycle; throughput is one word per WAIT_CYCLES+2 cycles with word_ready held 1.
REQ-032 Counters: the neuron counter wraps from N_HIDDEN-1 to 0 with is_output set at the layer switch; the word counter wraps at HID_WORDS (hidden) or OUT_WORDS (output).
REQ-033 last_word=1 only on the final weight word of each neuron, never on a bias.
REQ-034 start is ignored outside IDLE.
REQ-035 abort in any non-IDLE state forces IDLE next cycle: word_valid=0, ce=oe=0, no done pulse; abort beats a simultaneous handshake.
REQ-036 start and abort asserted together in IDLE: abort wins and the block stays IDLE.
REQ-037 ce=oe=0 in IDLE and DONE; we=0 always.

Reset
REQ-038 rst=1 at a clock edge forces IDLE, including mid-fetch.
REQ-039 During and after reset all outputs are 0: address, word, word_valid, is_bias, is_output, neuron, last_word, busy, done, ce, oe, we.
REQ-040 No partial state survives reset.

Structure
REQ-041 The state enum and the layout constants (N_HIDDEN, HID_WORDS, N_OUT, OUT_WORDS, layer base addresses) belong in the shared package digit_recognizer_pkg.
REQ-042 One sub-module, fetch_addr_gen, is natural: it holds the neuron/word counters and the address, is_bias, is_output and last_word generation.
REQ-043 The top level holds the FSM, the wait counter and the output registers.

Verification
REQ-044 Default parameters, word_ready=1, start pulse: 326 words on addresses 0..325; is_bias at 0,37,…,259,296,299,…,323; first valid at cycle 4; done pulse one cycle after address 325 is accepted.
REQ-045 Backpressure: word_ready=0 for 10 cycles at address 40; word, address and flags stay stable; acceptance then advances to address 41.
REQ-046 start pulsed at address 100 is ignored; the sweep completes normally with a single done pulse.
REQ-047 abort at address 200 during PRESENT: IDLE next cycle, no done; a new start restarts the fetch at address 0.
REQ-048 rst asserted at address 150: all outputs are 0 the following cycle; a subsequent start fetches from address 0.
REQ-049 WAIT_CYCLES=0: the word period is 2 cycles with word_ready=1, and data is captured correctly at each address.
